// File: rtl/async_fifo_reader.sv
// Read-domain drain engine: pops async_fifo words into a 3-entry buffer and streams them out on valid/ready.
// Optional delivered-word counter enabled by defining ASYNC_FIFO_READER_COUNT_EN.
module async_fifo_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic             drain_en,
    input  logic             empty,
    output logic             r_en,
    input  logic [WIDTH-1:0] r_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef ASYNC_FIFO_READER_COUNT_EN
    ,
    output logic [CNT_W-1:0] rd_count
`endif
);

    logic [1:0]       r_occ;
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf [0:2];

    logic             w_hs;
    logic [2:0]       w_pending;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop decision uses registered state only, so m_ready never reaches r_en combinationally.
    always_comb begin
        w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
        r_en      = r_rst_n & drain_en & ~empty & (w_pending < 3'd3);
        m_valid   = (r_occ != 2'd0);
        m_data    = r_buf[r_head];
        w_hs      = m_valid & m_ready;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= r_en;
            if (r_inflight) begin
                r_buf[r_tail] <= r_data;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_hs) begin
                r_head <= next_ptr(r_head);
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_hs};
        end
    end

`ifdef ASYNC_FIFO_READER_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_count <= '0;
        end else if (w_hs) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign rd_count = r_count;
`endif

endmodule
